// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS symbol constants and alignment state shared by encoder and decoder
package tmds_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] CTRL_TOKEN_0 = 10'h354;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_1 = 10'h0AB;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_2 = 10'h154;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_3 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return CTRL_TOKEN_0;
            2'b01:   return CTRL_TOKEN_1;
            2'b10:   return CTRL_TOKEN_2;
            default: return CTRL_TOKEN_3;
        endcase
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational TMDS symbol classifier and data decoder
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] symbol,
    output logic             is_ctrl,
    output logic [1:0]       ctrl,
    output logic [7:0]       data
);

    logic [7:0] q;

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (symbol)
            CTRL_TOKEN_0: ctrl = 2'b00;
            CTRL_TOKEN_1: ctrl = 2'b01;
            CTRL_TOKEN_2: ctrl = 2'b10;
            CTRL_TOKEN_3: ctrl = 2'b11;
            default:      is_ctrl = 1'b0;
        endcase
    end

    // bit 9 flags an inverted payload, bit 8 selects XOR vs XNOR chaining
    assign q = symbol[9] ? ~symbol[7:0] : symbol[7:0];

    always_comb begin
        data    = '0;
        data[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = symbol[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS channel decoder with control-token word alignment
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 4,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 16,
    parameter int LINE_TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] encoded,
    output logic [7:0]       dout,
    output logic [1:0]       ctrl,
    output logic             de,
    output logic             locked,
    output logic             bitslip
);

    localparam int MAX_AB  = (CTRL_RUN > SEARCH_TIMEOUT) ? CTRL_RUN : SEARCH_TIMEOUT;
    localparam int MAX_CD  = (SLIP_WAIT > LINE_TIMEOUT) ? SLIP_WAIT : LINE_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] RUN_LAST    = CW'(CTRL_RUN - 1);
    localparam logic [CW-1:0] SEARCH_LAST = CW'(SEARCH_TIMEOUT - 1);
    localparam logic [CW-1:0] SLIP_LAST   = CW'(SLIP_WAIT - 1);
    localparam logic [CW-1:0] LINE_LAST   = CW'(LINE_TIMEOUT - 1);

    logic [SYM_W-1:0] s1;
    state_t           state;
    logic [CW-1:0]    run;
    logic [CW-1:0]    timer;
    logic [CW-1:0]    gap;

    logic             sym_is_ctrl;
    logic [1:0]       sym_ctrl;
    logic [7:0]       sym_data;

    tmds_symbol_decode u_decode (
        .symbol  (s1),
        .is_ctrl (sym_is_ctrl),
        .ctrl    (sym_ctrl),
        .data    (sym_data)
    );

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            state   <= SEARCH;
            run     <= '0;
            timer   <= '0;
            gap     <= '0;
            dout    <= '0;
            ctrl    <= '0;
            de      <= 1'b0;
            locked  <= 1'b0;
            bitslip <= 1'b0;
        end else begin
            s1      <= encoded;
            bitslip <= 1'b0;
            locked  <= (state == LOCKED);
            de      <= ~sym_is_ctrl & (state == LOCKED);
            if (sym_is_ctrl) begin
                ctrl <= sym_ctrl;
                dout <= '0;
            end else begin
                dout <= sym_data;
            end

            case (state)
                SEARCH: begin
                    timer <= sat_inc(timer);
                    run   <= sym_is_ctrl ? sat_inc(run) : '0;
                    // a completed token run takes priority over a coincident timeout
                    if (sym_is_ctrl && run == RUN_LAST) begin
                        state <= LOCKED;
                        run   <= '0;
                        timer <= '0;
                        gap   <= '0;
                    end else if (timer == SEARCH_LAST) begin
                        state   <= SLIP;
                        bitslip <= 1'b1;
                        run     <= '0;
                        timer   <= '0;
                    end
                end
                SLIP: begin
                    if (timer == SLIP_LAST) begin
                        state <= SEARCH;
                        timer <= '0;
                        run   <= '0;
                    end else begin
                        timer <= sat_inc(timer);
                    end
                end
                LOCKED: begin
                    if (sym_is_ctrl) begin
                        gap <= '0;
                    end else if (gap == LINE_LAST) begin
                        state <= SEARCH;
                        gap   <= '0;
                        run   <= '0;
                        timer <= '0;
                    end else begin
                        gap <= sat_inc(gap);
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - scoreboard bench for tmds_decoder against a behavioural reference
module tb_tmds_decoder;

    localparam int P_RUN    = 4;
    localparam int P_SEARCH = 16;
    localparam int P_SLIP   = 4;
    localparam int P_LINE   = 32;

    localparam int M_SEARCH = 0;
    localparam int M_SLIP   = 1;
    localparam int M_LOCKED = 2;

    typedef struct packed {
        logic [7:0] dout;
        logic [1:0] ctrl;
        logic       de;
        logic       locked;
        logic       bitslip;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] encoded;
    logic [7:0] dout;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic       bitslip;

    always #5 clk = ~clk;

    tmds_decoder #(
        .CTRL_RUN       (P_RUN),
        .SEARCH_TIMEOUT (P_SEARCH),
        .SLIP_WAIT      (P_SLIP),
        .LINE_TIMEOUT   (P_LINE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .encoded (encoded),
        .dout    (dout),
        .ctrl    (ctrl),
        .de      (de),
        .locked  (locked),
        .bitslip (bitslip)
    );

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    exp_t       last_exp;
    exp_t       mon_e;
    bit         active = 1'b0;

    // reference model: symbol waiting in the pipeline plus link-level bookkeeping
    logic [9:0] ms1;
    int         m_state;
    int         m_age;
    int         m_run;
    int         m_gap;
    logic [1:0] m_ctrl;

    function automatic int tok_val(input logic [9:0] s);
        case (s)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [9:0] tok_sym(input int v);
        case (v)
            0:       return 10'h354;
            1:       return 10'h0AB;
            2:       return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] x;
        do x = 10'($urandom); while (tok_val(x) >= 0);
        return x;
    endfunction

    function automatic logic [7:0] decode_data(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~s[8];
        return d;
    endfunction

    task automatic model_reset();
        m_state = M_SEARCH;
        m_age   = 0;
        m_run   = 0;
        m_gap   = 0;
        m_ctrl  = 2'b00;
        ms1     = 10'h000;
    endtask

    task automatic model_enter(input int st);
        m_state = st;
        m_age   = 0;
        m_run   = 0;
        m_gap   = 0;
    endtask

    task automatic model_step(input logic [9:0] sym, output exp_t e);
        int tv;
        tv        = tok_val(sym);
        e.locked  = (m_state == M_LOCKED);
        e.de      = (tv < 0) && (m_state == M_LOCKED);
        e.bitslip = 1'b0;
        if (tv >= 0) begin
            m_ctrl = 2'(tv);
            e.dout = 8'h00;
        end else begin
            e.dout = decode_data(sym);
        end
        e.ctrl = m_ctrl;
        m_age++;
        if (m_state == M_SEARCH) begin
            m_run = (tv >= 0) ? m_run + 1 : 0;
            if (m_run >= P_RUN) begin
                model_enter(M_LOCKED);
            end else if (m_age >= P_SEARCH) begin
                model_enter(M_SLIP);
                e.bitslip = 1'b1;
            end
        end else if (m_state == M_SLIP) begin
            if (m_age >= P_SLIP) model_enter(M_SEARCH);
        end else begin
            m_gap = (tv >= 0) ? 0 : m_gap + 1;
            if (m_gap >= P_LINE) model_enter(M_SEARCH);
        end
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // pushes the expectation for the next edge, applies the symbol, returns after that edge
    task automatic drive(input logic [9:0] x);
        exp_t e;
        model_step(ms1, e);
        exp_q.push_back(e);
        last_exp = e;
        ms1      = x;
        encoded  = x;
        active   = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        active = 1'b0;
        exp_q.delete();
        rst_n  = 1'b0;
        #1;
        check("reset_outputs", {dout, ctrl, de, locked, bitslip}, 13'h0000);
        encoded = 10'h000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic bitslip_scan();
        for (int j = 0; j < 60; j++) begin
            drive(10'h100);
            check("bitslip_timing", 13'(bitslip), ((j + 1) % 20 == 16) ? 13'd1 : 13'd0);
            check("no_lock_on_data", 13'({locked, de}), 13'd0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (active) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("scoreboard", {dout, ctrl, de, locked, bitslip}, mon_e);
            end
        end
    end

    initial begin
        rst_n   = 1'b1;
        encoded = 10'h000;
        model_reset();
        @(negedge clk);

        // token run then data, data of both polarities, token after lock
        do_reset();
        repeat (4) drive(10'h354);
        drive(10'h100);
        check("ctrl_during_tokens", 13'(ctrl), 13'd0);
        drive(10'h200);
        check("lock_dout", 13'(dout), 13'h000);
        check("lock_de", 13'(de), 13'd1);
        check("lock_locked", 13'(locked), 13'd1);
        drive(10'h2AB);
        check("inv_dout", 13'(dout), 13'h0FF);
        check("inv_de", 13'(de), 13'd1);
        drive(10'h2AB);
        check("tok_de", 13'(de), 13'd0);
        check("tok_ctrl", 13'(ctrl), 13'd3);
        check("tok_dout", 13'(dout), 13'h000);

        // broken run does not lock, the following full run does
        do_reset();
        for (int j = 0; j < 10; j++) begin
            drive(j < 3 ? 10'h354 : (j == 3 ? 10'h100 : 10'h0AB));
            check("run_lock", 13'(locked), (j >= 9) ? 13'd1 : 13'd0);
        end
        check("run_ctrl", 13'(ctrl), 13'd1);

        // line timeout drops lock, a fresh run relocks
        do_reset();
        for (int j = 0; j < 41; j++) begin
            drive(j < 4 ? 10'h354 : rand_data());
            check("line_locked", 13'(locked), (j >= 5 && j <= 36) ? 13'd1 : 13'd0);
            check("line_de", 13'(de), (j >= 5 && j <= 36) ? 13'd1 : 13'd0);
        end
        repeat (6) drive(10'h354);
        check("relock", 13'(locked), 13'd1);

        // slip cadence on a stream without tokens
        do_reset();
        bitslip_scan();

        // reset while locked, then reset in the middle of a slip pulse
        do_reset();
        repeat (4) drive(10'h354);
        repeat (2) drive(10'h100);
        check("locked_before_reset", 13'(locked), 13'd1);
        do_reset();
        begin
            int n;
            n = 0;
            do begin
                drive(10'h100);
                n++;
            end while (!last_exp.bitslip && n < 40);
            check("bitslip_before_reset", 13'(bitslip), 13'd1);
        end
        do_reset();
        bitslip_scan();

        // random mix of token runs and data
        do_reset();
        for (int seg = 0; seg < 160; seg++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 24) == 0) do_reset();
            if (kind == 0) begin
                logic [9:0] t;
                t = tok_sym($urandom_range(0, 3));
                n = $urandom_range(1, 6);
                repeat (n) drive(t);
            end else if (kind == 1) begin
                n = $urandom_range(1, 40);
                repeat (n) drive(rand_data());
            end else begin
                n = $urandom_range(1, 12);
                repeat (n) drive($urandom_range(0, 1) ? tok_sym($urandom_range(0, 3)) : rand_data());
            end
        end

        active = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
